// File: rtl/stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register; single outstanding imem request.
// Optional FETCH_PERF_CNT_EN adds out_bubble_cycles, which counts cycles where IF/ID loads a bubble.
module stage_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_pc_write_disable,
   input  logic        in_IFID_write_disable,
   input  logic        in_branch_taken,
   input  logic [31:0] in_branch_target,
   output logic        out_imem_req,
   output logic [31:0] out_imem_addr,
   input  logic        in_imem_ready,
   input  logic [31:0] in_imem_rdata,
   output logic [31:0] out_instruction,
   output logic [31:0] out_PC,
   output logic        out_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] out_bubble_cycles
`endif
);

   typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] hold_buf, buf_next;
   logic        deliver;
   logic [31:0] deliver_instr;
   logic        load_bubble;

   assign out_imem_addr = pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         hold_buf <= '0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         hold_buf <= buf_next;
      end
   end

   always_comb begin
      state_next    = state;
      pc_next       = pc;
      buf_next      = hold_buf;
      deliver       = 1'b0;
      deliver_instr = hold_buf;
      out_imem_req  = 1'b0;
      case (state)
         FETCH: begin
            if (in_branch_taken) begin
               pc_next = in_branch_target;
            end else if (!in_pc_write_disable) begin
               out_imem_req = 1'b1;
               state_next   = WAIT;
            end
         end
         WAIT: begin
            if (in_imem_ready) begin
               if (in_branch_taken) begin
                  pc_next    = in_branch_target;
                  state_next = FETCH;
               end else if (!in_IFID_write_disable) begin
                  deliver       = 1'b1;
                  deliver_instr = in_imem_rdata;
                  pc_next       = pc + 32'd4;
                  state_next    = FETCH;
               end else begin
                  buf_next   = in_imem_rdata;
                  state_next = HOLD;
               end
            end else if (in_branch_taken) begin
               pc_next    = in_branch_target;
               state_next = DRAIN;
            end
         end
         HOLD: begin
            if (in_branch_taken) begin
               pc_next    = in_branch_target;
               buf_next   = '0;
               state_next = FETCH;
            end else if (!in_IFID_write_disable) begin
               deliver       = 1'b1;
               deliver_instr = hold_buf;
               pc_next       = pc + 32'd4;
               state_next    = FETCH;
            end
         end
         DRAIN: begin
            if (in_branch_taken) pc_next = in_branch_target;
            if (in_imem_ready) state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase
      if (reset) out_imem_req = 1'b0;
      // deliver already implies !IFID_write_disable, so "not bubble, not deliver" means hold
      load_bubble = in_branch_taken || (!in_IFID_write_disable && !deliver);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_instruction <= NOP_INSTR;
         out_PC          <= '0;
         out_valid       <= 1'b0;
      end else if (load_bubble) begin
         out_instruction <= NOP_INSTR;
         out_PC          <= '0;
         out_valid       <= 1'b0;
      end else if (deliver) begin
         out_instruction <= deliver_instr;
         out_PC          <= pc;
         out_valid       <= 1'b1;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) out_bubble_cycles <= '0;
      else if (load_bubble) out_bubble_cycles <= out_bubble_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch with a behavioural pipelined imem of programmable latency.
// Also checks out_bubble_cycles when FETCH_PERF_CNT_EN is defined.
module tb_stage_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        pcwd, ifwd, br;
   logic [31:0] tgt;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr, pc_out;
   logic        valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] bubbles;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   int unsigned mem_lat = 1;
   logic        use_override = 1'b0;
   logic        pend = 1'b0;
   int unsigned cnt = 0;
   logic [31:0] paddr = '0;

   always #5 clk = ~clk;

   stage_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
      .clk                  (clk),
      .reset                (reset),
      .in_pc_write_disable  (pcwd),
      .in_IFID_write_disable(ifwd),
      .in_branch_taken      (br),
      .in_branch_target     (tgt),
      .out_imem_req         (imem_req),
      .out_imem_addr        (imem_addr),
      .in_imem_ready        (imem_ready),
      .in_imem_rdata        (imem_rdata),
      .out_instruction      (instr),
      .out_PC               (pc_out),
      .out_valid            (valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .out_bubble_cycles    (bubbles)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h00A0_0093;
         32'h0000_0004: mem_word = 32'h0010_0113;
         32'h0000_0008: mem_word = 32'h0020_8193;
         default:       mem_word = {a[23:0], 8'h13};
      endcase
   endfunction

   // Memory captures the request on the clock edge and answers mem_lat cycles later.
   always @(posedge clk) begin
      if (reset) pend = 1'b0;
      else if (imem_req) begin
         pend  = 1'b1;
         paddr = imem_addr;
         cnt   = mem_lat;
      end
   end

   always @(negedge clk) begin
      imem_ready = 1'b0;
      if (reset) pend = 1'b0;
      else if (pend) begin
         if (cnt <= 1) begin
            imem_ready = 1'b1;
            imem_rdata = use_override ? 32'hDEAD_BEEF : mem_word(paddr);
            pend       = 1'b0;
         end else cnt = cnt - 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   initial begin
      reset = 1'b1; pcwd = 1'b0; ifwd = 1'b0; br = 1'b0; tgt = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_instr", instr, NOP);
      check("rst_pc", pc_out, 32'h0);
      check("rst_valid", {31'b0, valid}, 32'h0);
      check("rst_req", {31'b0, imem_req}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_bubbles", bubbles, 32'd0);
`endif
      // cycle 0..4: back-to-back fetches, latency 1
      @(negedge clk); reset = 1'b0; #1;
      check("c0_req", {31'b0, imem_req}, 32'h1);
      check("c0_addr", imem_addr, 32'h0);
      @(negedge clk); #1;
      check("c1_req", {31'b0, imem_req}, 32'h0);
      @(negedge clk); #1;
      check("c2_valid", {31'b0, valid}, 32'h1);
      check("c2_pc", pc_out, 32'h0);
      check("c2_instr", instr, 32'h00A0_0093);
      check("c2_req", {31'b0, imem_req}, 32'h1);
      check("c2_addr", imem_addr, 32'h4);
      @(negedge clk); #1;
      check("c3_valid", {31'b0, valid}, 32'h0);
      // cycle 4..8: IF/ID stalled while the response arrives -> HOLD
      @(negedge clk); ifwd = 1'b1; #1;
      check("c4_valid", {31'b0, valid}, 32'h1);
      check("c4_pc", pc_out, 32'h4);
      check("c4_instr", instr, 32'h0010_0113);
      check("c4_addr", imem_addr, 32'h8);
`ifdef FETCH_PERF_CNT_EN
      check("c4_bubbles", bubbles, 32'd2);
`endif
      @(negedge clk); #1;
      check("c5_req", {31'b0, imem_req}, 32'h0);
      @(negedge clk); #1;
      check("hold_req", {31'b0, imem_req}, 32'h0);
      check("hold_instr", instr, 32'h0010_0113);
      check("hold_pc", pc_out, 32'h4);
      @(negedge clk); #1;
      check("hold_valid", {31'b0, valid}, 32'h1);
      check("hold_req2", {31'b0, imem_req}, 32'h0);
      @(negedge clk); ifwd = 1'b0; #1;
      check("c8_req", {31'b0, imem_req}, 32'h0);
      // cycle 9..11: PC write disable in FETCH
      @(negedge clk); pcwd = 1'b1; #1;
      check("rel_instr", instr, 32'h0020_8193);
      check("rel_pc", pc_out, 32'h8);
      check("rel_valid", {31'b0, valid}, 32'h1);
      check("pcwd_req", {31'b0, imem_req}, 32'h0);
      check("pcwd_addr", imem_addr, 32'hC);
`ifdef FETCH_PERF_CNT_EN
      check("c9_bubbles", bubbles, 32'd2);
`endif
      @(negedge clk); #1;
      check("pcwd_req2", {31'b0, imem_req}, 32'h0);
      check("pcwd_addr2", imem_addr, 32'hC);
      check("pcwd_valid", {31'b0, valid}, 32'h0);
      @(negedge clk); pcwd = 1'b0; mem_lat = 2; use_override = 1'b1; #1;
      check("resume_req", {31'b0, imem_req}, 32'h1);
      check("resume_addr", imem_addr, 32'hC);
      // cycle 12..14: branch in WAIT, late response discarded via DRAIN
      @(negedge clk); br = 1'b1; tgt = 32'h0000_0100; #1;
      check("c12_req", {31'b0, imem_req}, 32'h0);
      @(negedge clk); br = 1'b0; mem_lat = 1; #1;
      check("drain_req", {31'b0, imem_req}, 32'h0);
      check("drain_valid", {31'b0, valid}, 32'h0);
      check("drain_instr", instr, NOP);
      @(negedge clk); use_override = 1'b0; #1;
      check("redir_req", {31'b0, imem_req}, 32'h1);
      check("redir_addr", imem_addr, 32'h100);
      check("redir_instr", instr, NOP);
      check("redir_valid", {31'b0, valid}, 32'h0);
      // cycle 15..18: branch coincident with ready and IF/ID stall
      @(negedge clk); #1;
      @(negedge clk); ifwd = 1'b1; #1;
      check("c16_valid", {31'b0, valid}, 32'h1);
      check("c16_pc", pc_out, 32'h100);
      check("c16_instr", instr, 32'h0001_0013);
      check("c16_addr", imem_addr, 32'h104);
      @(negedge clk); br = 1'b1; tgt = 32'h0000_0200; #1;
      check("c17_instr", instr, 32'h0001_0013);
      check("c17_ready", {31'b0, imem_ready}, 32'h1);
      @(negedge clk); br = 1'b0; ifwd = 1'b0; mem_lat = 2; #1;
      check("flush_instr", instr, NOP);
      check("flush_pc", pc_out, 32'h0);
      check("flush_valid", {31'b0, valid}, 32'h0);
      check("flush_req", {31'b0, imem_req}, 32'h1);
      check("flush_addr", imem_addr, 32'h200);
`ifdef FETCH_PERF_CNT_EN
      check("c18_bubbles", bubbles, 32'd9);
`endif
      // async reset mid-WAIT
      @(negedge clk); #1;
      check("c19_req", {31'b0, imem_req}, 32'h0);
      reset = 1'b1; #1;
      check("arst_addr", imem_addr, 32'h0);
      check("arst_req", {31'b0, imem_req}, 32'h0);
      check("arst_valid", {31'b0, valid}, 32'h0);
      check("arst_instr", instr, NOP);
`ifdef FETCH_PERF_CNT_EN
      check("arst_bubbles", bubbles, 32'd0);
`endif
      mem_lat = 1;
      repeat (2) @(negedge clk);
      reset = 1'b0; #1;
      check("r0_req", {31'b0, imem_req}, 32'h1);
      check("r0_addr", imem_addr, 32'h0);
      @(negedge clk); #1;
      // branch in FETCH suppresses the request; then PC wraps past 2^32
      @(negedge clk); br = 1'b1; tgt = 32'hFFFF_FFFC; #1;
      check("r2_valid", {31'b0, valid}, 32'h1);
      check("r2_instr", instr, 32'h00A0_0093);
      check("r2_req", {31'b0, imem_req}, 32'h0);
      @(negedge clk); br = 1'b0; #1;
      check("wrap_req", {31'b0, imem_req}, 32'h1);
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      @(negedge clk); #1;
      @(negedge clk); #1;
      check("wrap_valid", {31'b0, valid}, 32'h1);
      check("wrap_pc", pc_out, 32'hFFFF_FFFC);
      check("wrap_instr", instr, 32'hFFFF_FC13);
      check("wrap_next", imem_addr, 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
